// File: rtl/ad9958_reg_writer.sv
// AD9958 single-register write sequencer: builds the instruction+data frame,
// triggers the nibble-serial sender, tracks its busy and optionally pulses IO_UPDATE.
module ad9958_reg_writer #(
    parameter int unsigned IO_UPDATE_CYCLES = 4,
    parameter int unsigned BUSY_TIMEOUT     = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_update,
    input  logic        spi_busy,
    output logic        spi_trigger,
    output logic [4:0]  spi_packs,
    output logic [63:0] spi_data,
    output logic        io_update,
    output logic        done,
    output logic        error
);

    localparam int unsigned CW = ($clog2(BUSY_TIMEOUT + 1) > 8) ? $clog2(BUSY_TIMEOUT + 1) : 8;
    // The trigger cycle counts toward the busy-rise window, so WAIT_HI holds one cycle less.
    localparam logic [CW-1:0] HI_LAST  = CW'((BUSY_TIMEOUT > 1) ? BUSY_TIMEOUT - 2 : 0);
    localparam logic [CW-1:0] LO_LAST  = CW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] UPD_LAST = CW'((IO_UPDATE_CYCLES > 0) ? IO_UPDATE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_WAIT_HI,
        S_WAIT_LO,
        S_UPDATE,
        S_FIN,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   spi_data_q, spi_data_d;
    logic [4:0]    spi_packs_q, spi_packs_d;
    logic          update_q, update_d;

    logic [2:0]    bytes;
    logic [5:0]    shamt;
    logic [63:0]   ones;
    logic [63:0]   mask;
    logic [63:0]   frame;

    // Register width in bytes; zero marks an illegal address.
    function automatic logic [2:0] reg_bytes(input logic [4:0] addr);
        logic [2:0] b;
        case (addr)
            5'h00:   b = 3'd1;
            5'h01:   b = 3'd3;
            5'h02:   b = 3'd2;
            5'h03:   b = 3'd3;
            5'h04:   b = 3'd4;
            5'h05:   b = 3'd2;
            5'h06:   b = 3'd3;
            5'h07:   b = 3'd2;
            default: b = (addr <= 5'h18) ? 3'd4 : 3'd0;
        endcase
        return b;
    endfunction

    always_comb begin
        bytes = reg_bytes(cmd_addr);
        shamt = {bytes, 3'b000};
        ones  = '1;
        mask  = ~(ones << shamt);
        frame = ({56'd0, 3'b000, cmd_addr} << shamt) | ({32'd0, cmd_data} & mask);
    end

    always_comb begin
        state_d     = state_q;
        spi_data_d  = spi_data_q;
        spi_packs_d = spi_packs_q;
        update_d    = update_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (bytes != 3'd0) begin
                        state_d     = S_LOAD;
                        spi_data_d  = frame;
                        spi_packs_d = {1'b0, bytes, 1'b0} + 5'd2;
                        update_d    = cmd_update;
                    end else begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_LOAD:    state_d = S_TRIG;
            S_TRIG:    state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (spi_busy) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q >= HI_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_WAIT_LO: begin
                if (!spi_busy) begin
                    state_d = update_q ? S_UPDATE : S_FIN;
                end else if (cnt_q == LO_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_UPDATE: begin
                if (cnt_q == UPD_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == S_WAIT_HI || state_q == S_WAIT_LO || state_q == S_UPDATE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            spi_data_q  <= '0;
            spi_packs_q <= '0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            spi_data_q  <= spi_data_d;
            spi_packs_q <= spi_packs_d;
            update_q    <= update_d;
        end
    end

    // Outputs decode straight from the state flop so reset clears them asynchronously.
    assign cmd_ready   = (state_q == S_IDLE);
    assign spi_trigger = (state_q == S_TRIG);
    assign io_update   = (state_q == S_UPDATE);
    assign done        = (state_q == S_FIN);
    assign error       = (state_q == S_ABORT);
    assign spi_data    = spi_data_q;
    assign spi_packs   = spi_packs_q;

endmodule
